// File: rtl/set_job_scheduler.sv
// set_job_scheduler: round-robin arbiter that time-shares one SET circle-membership
// engine between NREQ requesters, with a watchdog guarding every engine run.
module set_job_scheduler #(
  parameter int NREQ        = 4,
  parameter int TIMEOUT_CYC = 100
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*24-1:0]       req_central,
  input  logic [NREQ*12-1:0]       req_radius,
  input  logic [NREQ*2-1:0]        req_mode,
  output logic [NREQ-1:0]          req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [7:0]               rsp_candidate,
  output logic                     rsp_timeout,
  output logic                     set_en,
  output logic [23:0]              set_central,
  output logic [11:0]              set_radius,
  output logic [1:0]               set_mode,
  input  logic                     set_busy,
  input  logic                     set_valid,
  input  logic [7:0]               set_candidate,
  output logic                     sch_busy
);
  localparam int IDW = $clog2(NREQ);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_RESP
  } state_t;

  state_t          state_reg;
  logic [IDW-1:0]  rr_ptr_reg;
  logic [7:0]      wdog_reg;
  logic [7:0]      wdog_next;
  logic [IDW-1:0]  rsp_id_reg;
  logic [7:0]      rsp_candidate_reg;
  logic            rsp_timeout_reg;
  logic [23:0]     set_central_reg;
  logic [11:0]     set_radius_reg;
  logic [1:0]      set_mode_reg;

  logic [23:0]     job_central [NREQ];
  logic [11:0]     job_radius  [NREQ];
  logic [1:0]      job_mode    [NREQ];

  logic            grant_found;
  logic [IDW-1:0]  grant_idx;
  logic            expired;
  logic            engine_done;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_job
    assign job_central[gi] = req_central[24*gi +: 24];
    assign job_radius[gi]  = req_radius[12*gi +: 12];
    assign job_mode[gi]    = req_mode[2*gi +: 2];
  end

  // First pending requester strictly after the last one served, wrapping around.
  always_comb begin
    int             slot;
    logic [IDW-1:0] slot_idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    slot        = 0;
    slot_idx    = '0;
    for (int i = 1; i <= NREQ; i++) begin
      slot = int'(rr_ptr_reg) + i;
      if (slot >= NREQ) slot = slot - NREQ;
      slot_idx = IDW'(slot);
      if (!grant_found && req_valid[slot_idx]) begin
        grant_found = 1'b1;
        grant_idx   = slot_idx;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_reg == S_IDLE && grant_found && !rst) req_ready[grant_idx] = 1'b1;
  end

  assign set_en        = (state_reg == S_LAUNCH) && !set_busy && !rst;
  assign rsp_valid     = (state_reg == S_RESP);
  assign sch_busy      = (state_reg != S_IDLE);
  assign rsp_id        = rsp_id_reg;
  assign rsp_candidate = rsp_candidate_reg;
  assign rsp_timeout   = rsp_timeout_reg;
  assign set_central   = set_central_reg;
  assign set_radius    = set_radius_reg;
  assign set_mode      = set_mode_reg;

  assign wdog_next   = (wdog_reg == 8'hFF) ? wdog_reg : wdog_reg + 8'd1;
  assign expired     = (wdog_reg == 8'(TIMEOUT_CYC - 1));
  assign engine_done = !set_busy && set_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= S_IDLE;
      rr_ptr_reg        <= IDW'(NREQ - 1);
      wdog_reg          <= 8'd0;
      rsp_id_reg        <= '0;
      rsp_candidate_reg <= 8'd0;
      rsp_timeout_reg   <= 1'b0;
      set_central_reg   <= 24'd0;
      set_radius_reg    <= 12'd0;
      set_mode_reg      <= 2'd0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (grant_found) begin
            set_central_reg <= job_central[grant_idx];
            set_radius_reg  <= job_radius[grant_idx];
            set_mode_reg    <= job_mode[grant_idx];
            rr_ptr_reg      <= grant_idx;
            state_reg       <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          // The set_en cycle is elapsed cycle 0, so the first wait cycle sees 1.
          if (!set_busy) begin
            wdog_reg  <= 8'd1;
            state_reg <= S_WAIT_BUSY;
          end
        end
        S_WAIT_BUSY: begin
          wdog_reg <= wdog_next;
          // Expiry beats a late busy rise so WAIT_DONE never starts past the limit.
          if (expired) begin
            rsp_id_reg        <= rr_ptr_reg;
            rsp_candidate_reg <= 8'd0;
            rsp_timeout_reg   <= 1'b1;
            state_reg         <= S_RESP;
          end else if (set_busy) begin
            state_reg <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          wdog_reg <= wdog_next;
          if (engine_done) begin
            rsp_id_reg        <= rr_ptr_reg;
            rsp_candidate_reg <= set_candidate;
            rsp_timeout_reg   <= 1'b0;
            state_reg         <= S_RESP;
          end else if (expired) begin
            rsp_id_reg        <= rr_ptr_reg;
            rsp_candidate_reg <= 8'd0;
            rsp_timeout_reg   <= 1'b1;
            state_reg         <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_set_job_scheduler.sv
// tb_set_job_scheduler: randomized jobs against a behavioural engine and a
// round-robin / response-timing reference model.
module tb_set_job_scheduler;
  localparam int NREQ = 4;
  localparam int TO   = 100;
  localparam int IDW  = $clog2(NREQ);

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*24-1:0]   req_central;
  logic [NREQ*12-1:0]   req_radius;
  logic [NREQ*2-1:0]    req_mode;
  logic [NREQ-1:0]      req_ready;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic [7:0]           rsp_candidate;
  logic                 rsp_timeout;
  logic                 set_en;
  logic [23:0]          set_central;
  logic [11:0]          set_radius;
  logic [1:0]           set_mode;
  logic                 set_busy;
  logic                 set_valid;
  logic [7:0]           set_candidate;
  logic                 sch_busy;

  set_job_scheduler #(.NREQ(NREQ), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_central(req_central), .req_radius(req_radius),
    .req_mode(req_mode), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_candidate(rsp_candidate), .rsp_timeout(rsp_timeout),
    .set_en(set_en), .set_central(set_central), .set_radius(set_radius),
    .set_mode(set_mode), .set_busy(set_busy), .set_valid(set_valid),
    .set_candidate(set_candidate), .sch_busy(sch_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Engine model: optional start delay, busy for eng_lat cycles, sticky valid.
  int          eng_lat    = 64;
  int          eng_delay  = 0;
  bit          eng_hang   = 1'b0;
  logic [7:0]  eng_result = 8'd0;
  logic        ext_busy   = 1'b0;
  logic        eng_busy_r = 1'b0;
  logic        eng_valid_r = 1'b0;
  logic [7:0]  eng_cand_r = 8'd0;
  int          eng_cnt    = 0;
  int          eng_pend   = 0;

  assign set_busy      = eng_busy_r | ext_busy;
  assign set_valid     = eng_valid_r;
  assign set_candidate = eng_cand_r;

  always @(posedge clk) begin
    if (set_en) begin
      if (eng_hang) begin
        eng_valid_r <= 1'b0;
      end else if (eng_delay == 0) begin
        eng_busy_r  <= 1'b1;
        eng_valid_r <= 1'b0;
        eng_cnt     <= eng_lat;
      end else begin
        eng_pend <= eng_delay;
      end
    end else if (eng_pend > 0) begin
      if (eng_pend == 1) begin
        eng_busy_r  <= 1'b1;
        eng_valid_r <= 1'b0;
        eng_cnt     <= eng_lat;
      end
      eng_pend <= eng_pend - 1;
    end else if (eng_busy_r) begin
      if (eng_cnt <= 1) begin
        eng_busy_r  <= 1'b0;
        eng_valid_r <= 1'b1;
        eng_cand_r  <= eng_result;
      end
      eng_cnt <= eng_cnt - 1;
    end
  end

  int vectors    = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Reference model state: last requester served.
  int          rr_last;
  logic [23:0] job_c [NREQ];
  logic [11:0] job_r [NREQ];
  logic [1:0]  job_m [NREQ];

  function automatic int rr_pick(input logic [NREQ-1:0] v);
    for (int i = 1; i <= NREQ; i++) begin
      int s;
      s = (rr_last + i) % NREQ;
      if (((v >> s) & 1) != 0) return s;
    end
    return -1;
  endfunction

  task automatic load_job(input int k, input logic [23:0] c, input logic [11:0] r, input logic [1:0] m);
    job_c[k] = c;
    job_r[k] = r;
    job_m[k] = m;
    req_central[24*k +: 24] = c;
    req_radius[12*k +: 12]  = r;
    req_mode[2*k +: 2]      = m;
  endtask

  task automatic load_random(input int k);
    load_job(k, 24'($urandom), 12'($urandom), 2'($urandom));
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_ctrl"}, 64'({req_ready, set_en, rsp_valid, rsp_timeout, sch_busy}), 64'(0));
    chk({tag, "_rsp"}, 64'({rsp_id, rsp_candidate}), 64'(0));
    chk({tag, "_set"}, 64'({set_central, set_radius, set_mode}), 64'(0));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((eng_busy_r || eng_pend != 0) && n < 300) begin
      tick();
      n++;
    end
  endtask

  // keep: 0 = drop request at accept, 1 = keep it, 2 = keep and drop all at response.
  // hold: cycles rsp_ready stays low after the first RESP cycle; <0 = held high throughout.
  task automatic run_job(input int lat, input int dly, input bit hang, input logic [7:0] cand,
                         input int pre, input int hold, input int keep);
    int             g, t0, t_en, t_rsp, n, stray, exp_d;
    bit             exp_to;
    logic [7:0]     exp_c;
    logic [IDW-1:0] gi;
    g  = rr_pick(req_valid);
    gi = IDW'(g);
    exp_to = hang || (lat + dly + 2 > TO);
    exp_d  = exp_to ? TO : lat + dly + 2;
    exp_c  = exp_to ? 8'd0 : cand;
    eng_lat = lat; eng_delay = dly; eng_hang = hang; eng_result = cand;
    if (pre > 0) ext_busy = 1'b1;
    rsp_ready = (hold < 0);
    #1;
    n = 0;
    while (req_ready == '0 && n < 20) begin
      tick();
      n++;
    end
    chk("grant", 64'(req_ready), 64'(1) << g);
    t0 = cyc;
    rr_last = g;
    tick();
    if (keep == 0) req_valid[gi] = 1'b0;
    for (int k = 0; k < pre; k++) begin
      #1;
      chk("launch_hold", 64'(set_en), 64'(0));
      tick();
    end
    ext_busy = 1'b0;
    #1;
    chk("set_en", 64'(set_en), 64'(1));
    t_en = cyc;
    chk("en_latency", 64'(t_en - t0), 64'(1 + pre));
    chk("set_job", 64'({set_central, set_radius, set_mode}), 64'({job_c[g], job_r[g], job_m[g]}));
    tick();
    chk("set_en_pulse", 64'(set_en), 64'(0));
    n = 0;
    stray = 0;
    while (!rsp_valid && n < 400) begin
      if (req_ready != '0 || set_en) stray++;
      tick();
      n++;
    end
    t_rsp = cyc;
    chk("stray_during_job", 64'(stray), 64'(0));
    chk("rsp_valid", 64'(rsp_valid), 64'(1));
    chk("rsp_delay", 64'(t_rsp - t_en), 64'(exp_d));
    chk("rsp_id", 64'(rsp_id), 64'(g));
    chk("rsp_candidate", 64'(rsp_candidate), 64'(exp_c));
    chk("rsp_timeout", 64'(rsp_timeout), 64'(exp_to));
    if (keep == 2) req_valid = '0;
    for (int k = 0; k < hold; k++) begin
      tick();
      chk("hold_rsp", 64'({rsp_valid, rsp_id, rsp_candidate, rsp_timeout}),
          64'({1'b1, gi, exp_c, exp_to}));
      chk("hold_quiet", 64'({req_ready, set_en}), 64'(0));
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    #1;
    chk("rsp_released", 64'(rsp_valid), 64'(0));
    $display("job req=%0d lat=%0d dly=%0d hang=%0b cand=%0d timeout=%0b rsp_after_en=%0d",
             g, lat, dly, hang, rsp_candidate, rsp_timeout, t_rsp - t_en);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int n, bad;
    rst = 1'b1;
    req_valid = '1;
    req_central = '0; req_radius = '0; req_mode = '0;
    rsp_ready = 1'b0;
    rr_last = NREQ - 1;
    repeat (3) tick();
    #1;
    chk("rst_no_grant", 64'({req_ready, set_en}), 64'(0));
    req_valid = '0;
    rst = 1'b0;
    #1;
    check_reset("por");

    // Single nominal job from requester 0.
    load_job(0, 24'h440000, 12'h200, 2'd0);
    req_valid = 4'b0001;
    run_job(64, 0, 1'b0, 8'd13, 0, 0, 0);

    // All requesters pending after a reset: order 0,1,2,3,0.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check_reset("rst2");
    rr_last = NREQ - 1;
    for (int k = 0; k < NREQ; k++) load_random(k);
    req_valid = '1;
    for (int j = 0; j < 5; j++)
      run_job(int'($urandom_range(1, 30)), 0, 1'b0, 8'($urandom), 0, -1, (j == 4) ? 2 : 1);

    // Hung engine, then a normal job from the same requester.
    load_random(2);
    req_valid = 4'b0100;
    run_job(64, 0, 1'b1, 8'($urandom), 0, 0, 0);
    drain();
    load_random(2);
    req_valid = 4'b0100;
    run_job(20, 0, 1'b0, 8'($urandom), 0, 0, 0);

    // Completion exactly at watchdog expiry, and one cycle too late.
    load_random(0);
    req_valid = 4'b0001;
    run_job(TO - 2, 0, 1'b0, 8'($urandom_range(1, 255)), 0, 0, 0);
    drain();
    load_random(0);
    req_valid = 4'b0001;
    run_job(TO - 1, 0, 1'b0, 8'($urandom_range(1, 255)), 0, 0, 0);
    drain();

    // Response backpressure with another request waiting.
    load_random(1);
    load_random(3);
    req_valid = 4'b1010;
    run_job(30, 0, 1'b0, 8'($urandom), 0, 10, 0);
    run_job(30, 0, 1'b0, 8'($urandom), 0, 0, 0);

    // Engine busy at launch, stale valid while the engine is slow to start.
    load_random(0);
    req_valid = 4'b0001;
    run_job(40, 2, 1'b0, 8'($urandom), 5, 0, 0);

    // Randomized jobs.
    for (int j = 0; j < 16; j++) begin
      for (int k = 0; k < NREQ; k++) load_random(k);
      req_valid = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      run_job(int'($urandom_range(1, 110)), int'($urandom_range(0, 2)),
              ($urandom_range(0, 9) == 0), 8'($urandom), int'($urandom_range(0, 2)),
              int'($urandom_range(0, 3)) - 1, 2);
      drain();
    end

    // Reset while waiting on the engine abandons the job.
    load_random(0);
    req_valid = 4'b0001;
    eng_lat = 64; eng_delay = 0; eng_hang = 1'b0;
    #1;
    n = 0;
    while (req_ready == '0 && n < 20) begin
      tick();
      n++;
    end
    chk("r6_grant", 64'(req_ready), 64'(1) << rr_pick(req_valid));
    repeat (12) tick();
    chk("r6_mid_job", 64'({sch_busy, rsp_valid}), 64'(2'b10));
    rst = 1'b1;
    req_valid = '0;
    tick();
    rst = 1'b0;
    #1;
    check_reset("r6");
    rr_last = NREQ - 1;
    bad = 0;
    for (int k = 0; k < 80; k++) begin
      tick();
      if (rsp_valid || sch_busy || set_en) bad++;
    end
    chk("r6_abandoned", 64'(bad), 64'(0));
    load_random(1);
    req_valid = 4'b0010;
    run_job(25, 0, 1'b0, 8'($urandom), 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
